// File: rtl/serial_subtractor_using_mux8x1.sv
// Bit-serial full subtractor, LSB first, one bit per clock.
// Difference and borrow per bit come from 8:1 muxes of constants.
module serial_subtractor_using_mux8x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_borrow;
    logic [CW-1:0]    r_count;

    logic [2:0]       w_sel;
    logic             w_d;
    logic             w_bo;

    assign w_sel = {r_a_sr[0], r_b_sr[0], r_borrow};

    // Truth tables as constant-input 8:1 muxes: DIFF 8'b1001_0110, BOR 8'b1000_1110
    always_comb begin
        w_d  = 1'b0;
        w_bo = 1'b0;
        unique case (w_sel)
            3'd0: begin w_d = 1'b0; w_bo = 1'b0; end
            3'd1: begin w_d = 1'b1; w_bo = 1'b1; end
            3'd2: begin w_d = 1'b1; w_bo = 1'b1; end
            3'd3: begin w_d = 1'b0; w_bo = 1'b1; end
            3'd4: begin w_d = 1'b1; w_bo = 1'b0; end
            3'd5: begin w_d = 1'b0; w_bo = 1'b0; end
            3'd6: begin w_d = 1'b0; w_bo = 1'b0; end
            3'd7: begin w_d = 1'b1; w_bo = 1'b1; end
            default: begin w_d = 1'b0; w_bo = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_borrow <= bin;
                        r_count  <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_count  <= r_count + 1'b1;
                    if (r_count == LAST) begin
                        r_bout  <= w_bo;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor_using_mux8x1.sv
// Directed and random checks of the bit-serial subtractor at WIDTH=8.
module tb_serial_subtractor_using_mux8x1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    int total = 0;
    int bad   = 0;

    serial_subtractor_using_mux8x1 #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; leaves the DUT in RUN.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibin);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        a = ia;
        b = ib;
        bin = ibin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (exp_lat > 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        else chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ir_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input logic ibin,
                      input logic [W-1:0] ed, input logic eb, input bit lat);
        issue(ia, ib, ibin);
        wait_done(tag, lat ? W : 0);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        consume(tag);
    endtask

    initial begin
        logic [W-1:0] hd;
        logic         hb;
        logic [W:0]   ref9;
        int           eps;
        logic         prev;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        op("t1", 8'd5, 8'd3, 1'b0, 8'h02, 1'b0, 1'b1);
        op("t2a", 8'd3, 8'd5, 1'b0, 8'hFE, 1'b1, 1'b1);
        op("t2b", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1, 1'b1);
        op("t3a", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
        op("t3b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Back-pressure: 60-25=35, no borrow
        issue(8'd60, 8'd25, 1'b0);
        wait_done("bp", W);
        hd = diff;
        hb = bout;
        chk("bp_diff", 32'(hd), 32'd35);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ov_hold", 32'(out_valid), 32'd1);
            chk("bp_diff_hold", 32'(diff), 32'(hd));
            chk("bp_bout_hold", 32'(bout), 32'(hb));
            chk("bp_ir_low", 32'(in_ready), 32'd0);
        end
        consume("bp");

        // Operands toggled during RUN must be ignored: 20-7=13
        issue(8'd20, 8'd7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = 8'hAA;
            b = 8'h11;
            bin = 1'b1;
            in_valid = ~in_valid;
            tick();
        end
        in_valid = 1'b0;
        wait_done("ign", 0);
        chk("ign_diff", 32'(diff), 32'd13);
        chk("ign_bout", 32'(bout), 32'd0);
        out_ready = 1'b1;
        eps = 1;
        prev = 1'b1;
        for (int i = 0; i < 2 * W + 4; i++) begin
            tick();
            out_ready = 1'b0;
            if (out_valid && !prev) eps++;
            prev = out_valid;
        end
        chk("ign_episodes", 32'(eps), 32'd1);

        // Reset in the middle of RUN
        issue(8'd9, 8'd2, 1'b0);
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_ir", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        eps = 0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (out_valid) eps++;
        end
        chk("mid_rst_no_ov", 32'(eps), 32'd0);
        op("t6", 8'd10, 8'd4, 1'b0, 8'd6, 1'b0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbi;
            ra = W'($urandom);
            rb = W'($urandom);
            rbi = 1'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
            op("rnd", ra, rb, rbi, ref9[W-1:0], ref9[W], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
